window_gen_5x5: RTL and testbench
=================================

# window_gen_5x5

Streaming 5x5 window generator that feeds the Gabor convolution blocks. It accepts one raster-order pixel per cycle, buffers the four previous image lines, and presents a full 5x5 neighbourhood on `pixel1`..`pixel25` for every position fully inside the image. The block is the upstream producer for the `convolution_block_*` pixel inputs and drives them with a valid/ready handshake.

## Interface
- `pixel_int_width`, 9: integer bits of a pixel (signed).
- `pixel_dec_width`, 0: fractional bits of a pixel.
- `BRAM_width`, 516: image width in pixels, which is also the line-buffer depth. Must be 5 or more.
- `image_height`, 516: image height in lines. Must be 5 or more.
- `kernel_size`, 5: fixed at 5; any other value is unsupported.

Ports (P = `pixel_int_width + pixel_dec_width`):
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_pixel` in P, signed: raster-order input pixel.
- `in_valid` in 1: `in_pixel` is valid.
- `in_ready` out 1: block can accept a pixel this cycle.
- `pixel1`..`pixel25` out P each, signed: window contents. `pixelN` is window row `(N-1)/5`, column `(N-1)%5`.
  - Row 0 is the oldest (top) line; column 0 is the oldest (left) pixel.
  - `pixel13` is the window centre; `pixelN` and `pixel(26-N)` are point-symmetric about it.
- `out_valid` out 1: window ports hold a valid window.
- `out_ready` in 1: downstream consumes the window.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accept rule: a pixel is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`, purely combinational.
- Counters: `col` runs 0..`BRAM_width`-1 and `row` runs 0..`image_height`-1; both advance only on accept.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after (`image_height`-1, `BRAM_width`-1), which starts the next frame.
- Line buffers: four memories, each `BRAM_width` deep and P wide, read combinationally at address `col`.
  - On accept, each buffer k is written with the value read from buffer k-1 at the same address; buffer 0 is written with `in_pixel`.
  - Reads happen before writes on the same address.
- Window shift register: 5x5 array of registers. On accept, every row shifts one column left.
  - Column 4 of rows 0..3 is loaded from buffers 3..0 (oldest line first).
  - Column 4 of row 4 is loaded from `in_pixel`.
- Output valid: on an accept at (`row`, `col`) with `row`>=4 and `col`>=4, `out_valid` is set for the next cycle.
  - Windows that would straddle a line or frame edge are never flagged valid. There is no padding.
- Handshake hold: while `out_valid && !out_ready`, no accept occurs, so the window, the counters and the buffers are all frozen.
  - `out_valid` clears after a cycle with `out_ready=1` unless a new qualifying accept happens in that same cycle.
- Simultaneous events: `out_ready=1` together with a new qualifying accept keeps `out_valid` at 1 and loads the new window. The output stream has no gap.
- `frame_done`: asserted the cycle after accepting pixel (`image_height`-1, `BRAM_width`-1).
- Outputs per frame: (`BRAM_width`-4)·(`image_height`-4).
- Data handling: pixel values are passed through unmodified, with no arithmetic and no width change.

## Timing
- Latency: the accept at cycle t sets `out_valid` at t+1, with that pixel on `pixel25`.
- Throughput: one pixel per cycle when `out_ready` is held at 1.
- Reset values: `out_valid`=0, `frame_done`=0, `row`=`col`=0, and all window registers (`pixel1`..`pixel25`)=0.
  - Line-buffer contents are not reset; they are don't-care until overwritten.
  - `in_ready` reads 1 during and after reset.
- Reset mid-frame: outputs drop to reset values immediately (asynchronously).
  - The next accepted pixel is treated as (0,0) of a new frame.
  - No stale window may be flagged valid until 4 full lines plus 5 pixels have been accepted.

## Test plan
Unless stated otherwise, tests use `BRAM_width`=8, `image_height`=6, and a ramp input where pixel(r,c)=8r+c.

- **First window:** drive the ramp with `out_ready`=1. `out_valid` first rises one cycle after the 37th accept, with `pixel1`=0, `pixel13`=18, `pixel25`=36.
- **Line wrap:** the window after (4,7) has `pixel25`=39. No valid output is produced for (5,0)..(5,3). The next window has `pixel1`=8 and `pixel25`=44. Exactly 8 windows are produced per frame.
- **Backpressure:** hold `out_ready`=0 after the first valid window for 10 cycles with `in_valid`=1. Required: `in_ready`=0, the window stays stable at `pixel25`=36, and no pixel is lost. After release, the next window has `pixel25`=37.
- **Frame boundary:** stream two back-to-back frames. `frame_done` pulses once per frame, the cycle after pixel 47 is accepted. The second frame's first window again has `pixel13`=18 relative to its ramp.
- **Reset mid-frame:** assert `rst` during row 3. `out_valid`, `frame_done` and all `pixelN` go to 0 immediately. Restarting the ramp reproduces the first-window result exactly.
- **Stalled input:** random `in_valid` gaps with `out_ready`=1. The windows produced match a golden raster model, and the count is still 8.

Source files
------------

// File: rtl/window_gen_5x5_if.sv
// Streaming handshake bundle between the pixel source, the 5x5 window
// generator and the convolution consumers.
interface window_gen_5x5_if #(
  parameter int P = 9
);
  logic signed [P-1:0] in_pixel;
  logic                in_valid;
  logic                in_ready;

  logic signed [P-1:0] pixel1,  pixel2,  pixel3,  pixel4,  pixel5;
  logic signed [P-1:0] pixel6,  pixel7,  pixel8,  pixel9,  pixel10;
  logic signed [P-1:0] pixel11, pixel12, pixel13, pixel14, pixel15;
  logic signed [P-1:0] pixel16, pixel17, pixel18, pixel19, pixel20;
  logic signed [P-1:0] pixel21, pixel22, pixel23, pixel24, pixel25;

  logic                out_valid;
  logic                out_ready;
  logic                frame_done;

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_valid, frame_done,
    output pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
    output pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
    output pixel11, pixel12, pixel13, pixel14, pixel15,
    output pixel16, pixel17, pixel18, pixel19, pixel20,
    output pixel21, pixel22, pixel23, pixel24, pixel25
  );

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_valid, frame_done,
    input  pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
    input  pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
    input  pixel11, pixel12, pixel13, pixel14, pixel15,
    input  pixel16, pixel17, pixel18, pixel19, pixel20,
    input  pixel21, pixel22, pixel23, pixel24, pixel25
  );
endinterface

// File: rtl/window_gen_5x5.sv
// Raster-order 5x5 window generator: four line buffers plus a 5x5 shift
// window; a window is flagged valid only when it lies fully inside the image.
module window_gen_5x5 #(
  parameter int pixel_int_width = 9,
  parameter int pixel_dec_width = 0,
  parameter int BRAM_width      = 516,
  parameter int image_height    = 516,
  parameter int kernel_size     = 5
) (
  input logic             clk,
  input logic             rst,
  window_gen_5x5_if.slave bus
);
  localparam int P   = pixel_int_width + pixel_dec_width;
  localparam int K   = kernel_size;
  localparam int NLB = K - 1;
  localparam int CW  = $clog2(BRAM_width);
  localparam int RW  = $clog2(image_height);

  localparam logic [CW-1:0] COL_LAST = CW'(BRAM_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(image_height - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

  typedef logic signed [P-1:0] pix_t;

  pix_t          lb_q [NLB][BRAM_width];
  pix_t          lb_rd_s [NLB];
  pix_t          win_q [K][K];
  pix_t          win_d [K][K];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          in_ready_s, accept_s, last_px_s, win_hit_s;

  assign in_ready_s = !out_valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign last_px_s  = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign win_hit_s  = (col_q >= COL_WIN) && (row_q >= ROW_WIN);

  // Combinational read of every line buffer at the current column.
  always_comb begin
    for (int k = 0; k < NLB; k++) begin
      lb_rd_s[k] = lb_q[k][col_q];
    end
  end

  // Line buffers cascade: each accept pushes the column one line older.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_q[0][col_q] <= bus.in_pixel;
      for (int k = 1; k < NLB; k++) begin
        lb_q[k][col_q] <= lb_rd_s[k-1];
      end
    end
  end

  // Next-state for the window, raster counters and output flags.
  always_comb begin
    win_d        = win_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    if (accept_s) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      // Oldest line (buffer NLB-1) lands in the top row.
      for (int r = 0; r < NLB; r++) begin
        win_d[r][K-1] = lb_rd_s[NLB-1-r];
      end
      win_d[K-1][K-1] = bus.in_pixel;
      frame_done_d    = last_px_s;
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else begin
      win_d = win_q;
    end
    if (accept_s && win_hit_s) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

  assign bus.pixel1  = win_q[0][0];
  assign bus.pixel2  = win_q[0][1];
  assign bus.pixel3  = win_q[0][2];
  assign bus.pixel4  = win_q[0][3];
  assign bus.pixel5  = win_q[0][4];
  assign bus.pixel6  = win_q[1][0];
  assign bus.pixel7  = win_q[1][1];
  assign bus.pixel8  = win_q[1][2];
  assign bus.pixel9  = win_q[1][3];
  assign bus.pixel10 = win_q[1][4];
  assign bus.pixel11 = win_q[2][0];
  assign bus.pixel12 = win_q[2][1];
  assign bus.pixel13 = win_q[2][2];
  assign bus.pixel14 = win_q[2][3];
  assign bus.pixel15 = win_q[2][4];
  assign bus.pixel16 = win_q[3][0];
  assign bus.pixel17 = win_q[3][1];
  assign bus.pixel18 = win_q[3][2];
  assign bus.pixel19 = win_q[3][3];
  assign bus.pixel20 = win_q[3][4];
  assign bus.pixel21 = win_q[4][0];
  assign bus.pixel22 = win_q[4][1];
  assign bus.pixel23 = win_q[4][2];
  assign bus.pixel24 = win_q[4][3];
  assign bus.pixel25 = win_q[4][4];
endmodule

// File: tb/tb_window_gen_5x5.sv
// Bench for window_gen_5x5 on an 8x6 image: ramp frames, backpressure,
// mid-frame reset and randomized traffic against a raster image model.
module tb_window_gen_5x5;
  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_gen_5x5_if #(.P(P)) bus ();

  window_gen_5x5 #(
    .pixel_int_width(9), .pixel_dec_width(0),
    .BRAM_width(W), .image_height(H), .kernel_size(5)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic signed [P-1:0] dut_win [25];
  assign dut_win[0]  = bus.pixel1;  assign dut_win[1]  = bus.pixel2;
  assign dut_win[2]  = bus.pixel3;  assign dut_win[3]  = bus.pixel4;
  assign dut_win[4]  = bus.pixel5;  assign dut_win[5]  = bus.pixel6;
  assign dut_win[6]  = bus.pixel7;  assign dut_win[7]  = bus.pixel8;
  assign dut_win[8]  = bus.pixel9;  assign dut_win[9]  = bus.pixel10;
  assign dut_win[10] = bus.pixel11; assign dut_win[11] = bus.pixel12;
  assign dut_win[12] = bus.pixel13; assign dut_win[13] = bus.pixel14;
  assign dut_win[14] = bus.pixel15; assign dut_win[15] = bus.pixel16;
  assign dut_win[16] = bus.pixel17; assign dut_win[17] = bus.pixel18;
  assign dut_win[18] = bus.pixel19; assign dut_win[19] = bus.pixel20;
  assign dut_win[20] = bus.pixel21; assign dut_win[21] = bus.pixel22;
  assign dut_win[22] = bus.pixel23; assign dut_win[23] = bus.pixel24;
  assign dut_win[24] = bus.pixel25;

  int checks = 0;
  int errors = 0;
  int ramp_base = 0;
  bit ramp_mode = 1'b1;
  bit rand_rdy  = 1'b0;

  // Reference model: the current frame as a plain image plus the expected outputs.
  int img [H][W];
  int exp_win [25];
  bit exp_valid = 1'b0;
  bit exp_fd    = 1'b0;
  int exp_idx   = 0;
  int exp_base  = 0;
  bit exp_ramp  = 1'b0;
  int cur_base  = 0;
  bit cur_ramp  = 1'b0;
  int mr = 0;
  int mc = 0;
  int hs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then model update for this cycle's accept.
  always @(negedge clk) begin
    bit acc;
    int bad;
    int pend;
    if (rst) begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
      mr = 0;
      mc = 0;
      hs = 0;
    end else begin
      chk("out_valid", int'(bus.out_valid), int'(exp_valid));
      chk("frame_done", int'(bus.frame_done), int'(exp_fd));
      chk("in_ready", int'(bus.in_ready), int'(!exp_valid || bus.out_ready));
      if (exp_valid) begin
        bad = -1;
        for (int i = 0; i < 25; i++) begin
          if (bad < 0 && int'(dut_win[i]) != exp_win[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL window pixel%0d: got %0d expected %0d at %0t",
                   bad + 1, int'(dut_win[bad]), exp_win[bad], $time);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        hs++;
        if (exp_valid && exp_ramp) begin
          if (exp_idx == 0) begin
            chk("first_pixel1", int'(dut_win[0]), exp_base + 0);
            chk("first_pixel13", int'(dut_win[12]), exp_base + 18);
            chk("first_pixel25", int'(dut_win[24]), exp_base + 36);
          end
          if (exp_idx == 1) chk("after_bp_pixel25", int'(dut_win[24]), exp_base + 37);
          if (exp_idx == 3) chk("row_end_pixel25", int'(dut_win[24]), exp_base + 39);
          if (exp_idx == 4) begin
            chk("wrap_pixel1", int'(dut_win[0]), exp_base + 8);
            chk("wrap_pixel25", int'(dut_win[24]), exp_base + 44);
          end
        end
      end
      if (bus.frame_done) begin
        pend = (bus.out_valid && !bus.out_ready) ? 1 : 0;
        chk("windows_per_frame", hs + pend, 8);
        hs = -pend;
      end

      acc    = bus.in_valid && (!exp_valid || bus.out_ready);
      exp_fd = 1'b0;
      if (acc) begin
        if (mr == 0 && mc == 0) begin
          cur_base = ramp_base;
          cur_ramp = ramp_mode;
        end
        img[mr][mc] = int'(bus.in_pixel);
        if (mr >= 4 && mc >= 4) begin
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
              exp_win[i*5+j] = img[mr-4+i][mc-4+j];
          exp_idx   = (mr - 4) * (W - 4) + (mc - 4);
          exp_base  = cur_base;
          exp_ramp  = cur_ramp;
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
        end
        exp_fd = (mr == H - 1) && (mc == W - 1);
        mc++;
        if (mc == W) begin
          mc = 0;
          mr++;
          if (mr == H) mr = 0;
        end
      end else if (bus.out_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pixel = P'(v);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of %0d", v);
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < W * H; k++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send(int'($urandom_range(0, 511)) - 256);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 25; i++) chk($sformatf("rst_pixel%0d", i + 1), int'(dut_win[i]), 0);
    bus.out_ready = 1'b1;
    rst = 1'b0;

    // Frame A: ramp with a 10-cycle stall after the first window.
    ramp_base = 0;
    for (int k = 0; k < 37; k++) send(k);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pixel  = P'(37);
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_pixel25", int'(dut_win[24]), 36);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int k = 37; k < 48; k++) send(k);

    // Frame B back to back.
    ramp_base = 100;
    for (int k = 0; k < 48; k++) send(100 + k);

    // Frame C: reset during row 3.
    ramp_base = 50;
    for (int k = 0; k < 28; k++) send(50 + k);
    chk("pre_reset_pixel25", int'(dut_win[24]), 77);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_frame_done", int'(bus.frame_done), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 25; i++) chk($sformatf("mid_rst_pixel%0d", i + 1), int'(dut_win[i]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Frame D: clean ramp after reset.
    ramp_base = 0;
    for (int k = 0; k < 48; k++) send(k);

    // Random data with input gaps, then with random downstream stalls.
    ramp_mode = 1'b0;
    rand_frame();
    rand_frame();
    rand_rdy = 1'b1;
    rand_frame();
    rand_frame();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
